// File: rtl/spart_rx.sv
// SPART receive front end: 16x-oversampled 8N1 UART receiver feeding a small
// byte FIFO, with sticky framing-error and overrun flags.
module spart_rx #(
    parameter int DIV        = 54,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxd,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                state;
    logic                  s1;
    logic                  rs;
    logic [15:0]           tcnt;
    logic [3:0]            sc;
    logic [2:0]            bi;
    logic [7:0]            shreg;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;

    logic tick;
    logic mid;
    logic push;
    logic ferr_evt;
    logic full;
    logic pop;
    logic wr;
    logic ovr_evt;

    assign tick     = (tcnt == 16'(DIV - 1));
    assign mid      = tick && (sc == 4'd7);
    assign push     = (state == STOP) && mid && rs;
    assign ferr_evt = (state == STOP) && mid && !rs;
    assign full     = (rx_count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign pop      = rd && (rx_count != '0);
    assign wr       = push && (!full || pop);
    assign ovr_evt  = push && full && !pop;

    assign rx_data  = mem[rp];
    assign rx_valid = (rx_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            rs <= 1'b1;
        end else begin
            s1 <= rxd;
            rs <= s1;
        end
    end

    // The IDLE->START edge is the tick counter's first cycle, so every
    // sample lands on the last clk of a k*DIV window measured from the
    // first low rs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tcnt  <= '0;
            sc    <= '0;
            bi    <= '0;
        end else begin
            if (state != IDLE) begin
                tcnt <= tick ? 16'd0 : tcnt + 16'd1;
                if (tick)
                    sc <= sc + 4'd1;
            end
            case (state)
                IDLE: begin
                    if (!rs) begin
                        state <= START;
                        tcnt  <= 16'd1;
                        sc    <= '0;
                        bi    <= '0;
                    end else begin
                        tcnt  <= '0;
                    end
                end
                START: begin
                    if (mid)
                        state <= rs ? IDLE : DATA;
                end
                DATA: begin
                    if (mid) begin
                        if (bi == 3'd7)
                            state <= STOP;
                        else
                            bi <= bi + 3'd1;
                    end
                end
                STOP: begin
                    if (mid)
                        state <= rs ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (rs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && mid)
            shreg <= {rs, shreg[7:1]};
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            rx_count <= '0;
        end else begin
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            case ({wr, pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    // Set wins over clear when both land in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_evt | (frame_err & ~clr_err);
            overrun   <= ovr_evt  | (overrun   & ~clr_err);
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed scenarios plus randomized frames, with a
// queue-based FIFO model and a monitor that pops and compares bytes.
module tb_spart_rx;

    localparam int DIV  = 4;
    localparam int BITC = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       rd;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int         vectors = 0;
    int         errors  = 0;
    bit         drain   = 1'b0;
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    logic [7:0] exp_q[$];

    spart_rx #(.DIV(DIV), .DEPTH_LOG2(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rd       (rd),
        .clr_err  (clr_err),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_count (rx_count),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model update happens when the frame starts so the monitor can pop early.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bt, input int pop_at);
        int el;
        logic v;
        el = 0;
        if (stop_ok) begin
            if (pop_at >= 0) begin
                void'(exp_q.pop_front());
                exp_q.push_back(b);
            end else if (!drain && exp_q.size() == 4) begin
                exp_ovr = 1'b1;
            end else begin
                exp_q.push_back(b);
            end
        end else begin
            exp_ferr = 1'b1;
        end
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop_ok;
            else             v = b[k-1];
            rxd = v;
            for (int c = 0; c < bt; c++) begin
                if (pop_at >= 0 && el == pop_at)     rd = 1'b1;
                if (pop_at >= 0 && el == pop_at + 1) rd = 1'b0;
                @(negedge clk);
                el++;
            end
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_all(input string name);
        int n;
        n = 0;
        drain = 1'b1;
        @(negedge clk);
        while ((rx_valid || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        drain = 1'b0;
        rd = 1'b0;
        check({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        check({name, "_empty"}, 32'(rx_valid), 32'd0);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    // Monitor: while draining, every byte presented is popped and compared.
    initial begin
        forever begin
            @(negedge clk);
            if (drain) begin
                if (rx_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h, expected none", rx_data);
                    end else begin
                        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                    end
                    rd = 1'b1;
                end else begin
                    rd = 1'b0;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [7:0] b;
        bit ok;
        rst = 1'b0;
        rxd = 1'b1;
        rd = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b1;
        idle(10);

        // 1: single byte with latency measurement
        fork
            send_frame(8'hA5, 1'b1, BITC, -1);
            begin
                n = 0;
                while (!rx_valid && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("t1_latency", 32'(n), 32'(152 * DIV + 2));
            end
        join
        check("t1_data", 32'(rx_data), 32'(exp_q[0]));
        check("t1_count", 32'(rx_count), 32'd1);
        void'(exp_q.pop_front());
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check("t1_valid_after_pop", 32'(rx_valid), 32'd0);
        check("t1_count_after_pop", 32'(rx_count), 32'd0);
        idle(20);

        // 2: overrun
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 1'b1, BITC, -1);
        check("t2_count", 32'(rx_count), 32'(exp_q.size()));
        check("t2_ovr", 32'(overrun), 32'(exp_ovr));
        drain_all("t2");
        pulse_clr();
        check("t2_ovr_clr", 32'(overrun), 32'(exp_ovr));
        idle(20);

        // 3: framing error and held break
        send_frame(8'h3C, 1'b0, BITC, -1);
        check("t3_ferr", 32'(frame_err), 32'(exp_ferr));
        pulse_clr();
        repeat (3 * BITC) @(negedge clk);
        check("t3_ferr_once", 32'(frame_err), 32'(exp_ferr));
        idle(2 * BITC);
        check("t3_discard", 32'(rx_count), 32'd0);
        send_frame(8'h7E, 1'b1, BITC, -1);
        check("t3_count", 32'(rx_count), 32'(exp_q.size()));
        check("t3_ferr_end", 32'(frame_err), 32'(exp_ferr));
        drain_all("t3");
        idle(20);

        // 4: start glitch
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        idle(BITC + 20);
        check("t4_count", 32'(rx_count), 32'd0);
        check("t4_ferr", 32'(frame_err), 32'(exp_ferr));
        check("t4_ovr", 32'(overrun), 32'(exp_ovr));
        send_frame(8'h55, 1'b1, BITC, -1);
        drain_all("t4");
        idle(20);

        // 5: push while full with a simultaneous pop
        for (int i = 0; i < 4; i++)
            send_frame(8'hC0 + 8'(i), 1'b1, BITC, -1);
        check("t5_full", 32'(rx_count), 32'd4);
        send_frame(8'hC4, 1'b1, BITC, 152 * DIV - 1);
        check("t5_ovr", 32'(overrun), 32'(exp_ovr));
        check("t5_count", 32'(rx_count), 32'(exp_q.size()));
        check("t5_head", 32'(rx_data), 32'(exp_q[0]));
        drain_all("t5");
        idle(20);

        // 6: reset in the middle of a frame
        send_frame(8'h81, 1'b1, BITC, -1);
        send_frame(8'h42, 1'b1, BITC, -1);
        check("t6_count_pre", 32'(rx_count), 32'd2);
        fork
            send_frame(8'hFF, 1'b1, BITC, -1);
            begin
                repeat (5 * BITC) @(negedge clk);
                rst = 1'b0;
                #1;
                exp_q.delete();
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
                check("t6_count_rst", 32'(rx_count), 32'd0);
                check("t6_valid_rst", 32'(rx_valid), 32'd0);
            end
        join
        rst = 1'b1;
        idle(20);
        send_frame(8'h12, 1'b1, BITC, -1);
        check("t6_count_post", 32'(rx_count), 32'd1);
        drain_all("t6");
        idle(20);

        // Randomized frames with +/-3% baud error and occasional bad stops
        drain = 1'b1;
        for (int i = 0; i < 30; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 9) != 0);
            send_frame(b, ok, $urandom_range(62, 66), -1);
            check("rnd_ferr", 32'(frame_err), 32'(exp_ferr));
            check("rnd_ovr", 32'(overrun), 32'(exp_ovr));
            if (!ok) pulse_clr();
            idle(ok ? $urandom_range(0, 30) : $urandom_range(16, 40));
        end
        drain_all("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
